// File: rtl/foreground_sched_m.sv
// Per-scanline object scheduler: scans Object Memory Y bytes, queues up to MAX_PER_LINE hits in index order.
// Define FOREGROUND_SCHED_HIDE_EN to treat Y == 8'hFF as a disabled object.
module foreground_sched_m #(
    parameter int NUM_OBJECTS  = 64,
    parameter int MAX_PER_LINE = 8
) (
    input  logic                            gpu_clk,
    input  logic                            rst,
    input  logic                            line_start,
    input  logic [8:0]                      next_y,
    output logic [5:0]                      obm_index,
    input  logic [7:0]                      obm_y,
    output logic                            slot_valid,
    output logic [5:0]                      slot_index,
    input  logic                            slot_ready,
    output logic                            busy,
    output logic                            done,
    output logic [$clog2(MAX_PER_LINE):0]   count,
    output logic                            overflow,
    output logic                            late
);

    localparam int CW    = $clog2(MAX_PER_LINE) + 1;
    localparam int PTR_W = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;
    localparam logic [5:0]    LAST_IDX = 6'(NUM_OBJECTS - 1);
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_PER_LINE);

    typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DRAIN} state_t;

    state_t             state, state_nxt;
    logic [8:0]         y_r;
    logic               cmp_valid;
    logic [5:0]         cmp_idx;
    logic [8:0]         y_diff;
    logic               y_hidden;
    logic               hit, accept, reject;
    logic               push, pop;
    logic [5:0]         fifo_mem [MAX_PER_LINE];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]      occ;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_PER_LINE - 1)) ? '0 : p + PTR_W'(1);
    endfunction

`ifdef FOREGROUND_SCHED_HIDE_EN
    assign y_hidden = (obm_y == 8'hFF);
`else
    assign y_hidden = 1'b0;
`endif

    // Objects occupy 8 rows starting at their Y; no wrap through line 0.
    always_comb begin
        y_diff = y_r - {1'b0, obm_y};
        hit    = cmp_valid && (y_diff < 9'd8) && !y_hidden;
        accept = hit && (count < MAX_CNT);
        reject = hit && (count == MAX_CNT);
        push   = accept && !line_start;
        pop    = slot_valid && slot_ready;
    end

    always_ff @(posedge gpu_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (line_start) begin
            state_nxt = SCAN;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                SCAN: begin
                    if (reject) begin
                        state_nxt = DRAIN;
                    end else if (obm_index == LAST_IDX) begin
                        state_nxt = FLUSH;
                    end
                end
                FLUSH:   state_nxt = DRAIN;
                DRAIN: begin
                    if (occ == '0) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign done       = (state == DRAIN) && (occ == '0);
    assign slot_valid = (occ != '0);
    assign slot_index = slot_valid ? fifo_mem[rd_ptr] : 6'd0;

    // Address walk and compare pipeline; an overflow drops the compare already in flight.
    always_ff @(posedge gpu_clk or posedge rst) begin
        if (rst) begin
            y_r       <= '0;
            obm_index <= '0;
            cmp_valid <= 1'b0;
            cmp_idx   <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            late      <= 1'b0;
        end else if (line_start) begin
            y_r       <= next_y;
            obm_index <= '0;
            cmp_valid <= 1'b0;
            count     <= '0;
            overflow  <= 1'b0;
            late      <= (state != IDLE);
        end else begin
            cmp_valid <= (state == SCAN) && !reject;
            cmp_idx   <= obm_index;
            if ((state == SCAN) && !reject && (obm_index != LAST_IDX)) begin
                obm_index <= obm_index + 6'd1;
            end
            if (accept) begin
                count <= count + CW'(1);
            end
            if (reject) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge gpu_clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (line_start) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Storage needs no reset: slot_index is masked while the FIFO is empty.
    always_ff @(posedge gpu_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= cmp_idx;
        end
    end

endmodule

// File: tb/tb_foreground_sched_m.sv
// Randomized self-checking bench for foreground_sched_m against a per-line selection model.
module tb_foreground_sched_m;

    localparam int NUM  = 64;
    localparam int MAXP = 8;

    logic       gpu_clk, rst, line_start, slot_ready;
    logic [8:0] next_y;
    logic [5:0] obm_index, slot_index;
    logic [7:0] obm_y;
    logic       slot_valid, busy, done, overflow, late;
    logic [3:0] count;
    logic [7:0] obj_y [NUM];

    int checks   = 0;
    int failures = 0;

    foreground_sched_m #(.NUM_OBJECTS(NUM), .MAX_PER_LINE(MAXP)) dut (
        .gpu_clk    (gpu_clk),
        .rst        (rst),
        .line_start (line_start),
        .next_y     (next_y),
        .obm_index  (obm_index),
        .obm_y      (obm_y),
        .slot_valid (slot_valid),
        .slot_index (slot_index),
        .slot_ready (slot_ready),
        .busy       (busy),
        .done       (done),
        .count      (count),
        .overflow   (overflow),
        .late       (late)
    );

    initial begin
        gpu_clk = 1'b0;
        forever #5 gpu_clk = ~gpu_clk;
    end

    // Object Memory with a one-cycle registered read
    always @(posedge gpu_clk) obm_y <= obj_y[obm_index];

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    function automatic bit hitModel(input int ny, input int y);
        int d;
        d = ((ny - y) % 512 + 512) % 512;
`ifdef FOREGROUND_SCHED_HIDE_EN
        if (y == 255) return 1'b0;
`endif
        return d < 8;
    endfunction

    task automatic fillAll(input int y);
        for (int i = 0; i < NUM; i++) obj_y[i] = 8'(y);
    endtask

    task automatic nextCycle();
        @(posedge gpu_clk);
        #1;
    endtask

    task automatic startLine(input int ny);
        line_start = 1'b1;
        next_y     = 9'(ny);
        nextCycle();
        line_start = 1'b0;
    endtask

    // Called in cycle 1 of a line; follows it to done and compares with the model.
    task automatic monitorLine(input int ny, input int hold, input int readyPct, input int expLate);
        int  expIdx[$];
        int  gotIdx[$];
        int  gotCyc[$];
        int  j9, drainEntry, doneCyc, stableErr, heldIdx, expDone, n;
        bit  ovf, heldValid;
        ovf = 1'b0; j9 = -1; doneCyc = -1; stableErr = 0; heldValid = 1'b0; heldIdx = 0;
        for (int i = 0; i < NUM; i++) begin
            if (hitModel(ny, int'(obj_y[i]))) begin
                if (expIdx.size() < MAXP) expIdx.push_back(i);
                else if (!ovf) begin ovf = 1'b1; j9 = i; end
            end
        end
        drainEntry = ovf ? j9 + 3 : NUM + 2;

        checkOutput("busy_c1", int'(busy), 1);
        checkOutput("obm_index_c1", int'(obm_index), 0);
        checkOutput("late_c1", int'(late), expLate);

        for (int cyc = 1; cyc < 3000; cyc++) begin
            slot_ready = (cyc < hold) ? 1'b0 : (int'($urandom_range(99)) < readyPct);
            if (cyc == 31 && drainEntry > 31) checkOutput("obm_index_c31", int'(obm_index), 30);
            if (heldValid && (!slot_valid || int'(slot_index) != heldIdx)) stableErr++;
            if (slot_valid && slot_ready) begin
                gotIdx.push_back(int'(slot_index));
                gotCyc.push_back(cyc);
                heldValid = 1'b0;
            end else if (slot_valid) begin
                heldValid = 1'b1;
                heldIdx   = int'(slot_index);
            end else begin
                heldValid = 1'b0;
            end
            if (done) begin
                doneCyc = cyc;
                break;
            end
            nextCycle();
        end
        slot_ready = 1'b0;

        if (doneCyc < 0) begin
            checkOutput("done_timeout", 0, 1);
        end else begin
            checkOutput("count", int'(count), expIdx.size());
            checkOutput("overflow", int'(overflow), int'(ovf));
            checkOutput("busy_at_done", int'(busy), 1);
            expDone = drainEntry;
            if (gotCyc.size() > 0 && gotCyc[gotCyc.size()-1] + 1 > expDone)
                expDone = gotCyc[gotCyc.size()-1] + 1;
            checkOutput("done_cycle", doneCyc, expDone);
            nextCycle();
            checkOutput("busy_after_done", int'(busy), 0);
            checkOutput("done_one_pulse", int'(done), 0);
        end
        checkOutput("n_slots", gotIdx.size(), expIdx.size());
        n = (gotIdx.size() < expIdx.size()) ? gotIdx.size() : expIdx.size();
        for (int i = 0; i < n; i++) begin
            checkOutput("slot_index", gotIdx[i], expIdx[i]);
            checkOutput("slot_not_early", int'(gotCyc[i] >= expIdx[i] + 3), 1);
        end
        checkOutput("slot_stable", stableErr, 0);
    endtask

    task automatic applyStimulus(input int ny, input int hold, input int readyPct, input int expLate);
        startLine(ny);
        monitorLine(ny, hold, readyPct, expLate);
    endtask

    initial begin
        int ny;
        rst        = 1'b1;
        line_start = 1'b0;
        next_y     = '0;
        slot_ready = 1'b0;
        fillAll(8'hF0);
        repeat (3) @(posedge gpu_clk);
        #1;
        rst = 1'b0;
        nextCycle();
        checkOutput("rst_obm_index", int'(obm_index), 0);
        checkOutput("rst_slot_valid", int'(slot_valid), 0);
        checkOutput("rst_slot_index", int'(slot_index), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_count", int'(count), 0);
        checkOutput("rst_overflow", int'(overflow), 0);
        checkOutput("rst_late", int'(late), 0);

        // No hits
        fillAll(8'hF0);
        applyStimulus(10, 0, 100, 0);

        // Three hits, then the line just past their last row
        obj_y[5] = 8'd8; obj_y[20] = 8'd8; obj_y[63] = 8'd8;
        applyStimulus(15, 0, 100, 0);
        applyStimulus(16, 0, 100, 0);

        // Everyone hits: limit and overflow
        fillAll(100);
        applyStimulus(100, 0, 100, 0);

        // Long backpressure on two hits
        fillAll(8'hF0);
        obj_y[7] = 8'd50; obj_y[40] = 8'd47;
        applyStimulus(52, 110, 100, 0);

        // No wrap across line 0
        fillAll(8'hF0);
        obj_y[3] = 8'hFC;
        applyStimulus(2, 0, 100, 0);

        // Y = 0xFF
        fillAll(8'hF0);
        obj_y[0] = 8'hFF;
        applyStimulus(255, 0, 100, 0);

        // Late line_start in cycle 30 with entries queued
        fillAll(8'hF0);
        obj_y[2] = 8'd60; obj_y[3] = 8'd61;
        slot_ready = 1'b0;
        startLine(64);
        repeat (29) nextCycle();
        checkOutput("late_prefill", int'(slot_valid), 1);
        line_start = 1'b1;
        next_y     = 9'd64;
        nextCycle();
        line_start = 1'b0;
        checkOutput("late_flushed", int'(slot_valid), 0);
        checkOutput("late_count_clr", int'(count), 0);
        monitorLine(64, 0, 100, 1);
        checkOutput("late_sticky", int'(late), 1);
        applyStimulus(64, 0, 100, 0);

        // Asynchronous reset mid-scan
        startLine(64);
        repeat (19) nextCycle();
        rst = 1'b1;
        #1;
        checkOutput("arst_busy", int'(busy), 0);
        checkOutput("arst_slot_valid", int'(slot_valid), 0);
        checkOutput("arst_obm_index", int'(obm_index), 0);
        checkOutput("arst_count", int'(count), 0);
        nextCycle();
        checkOutput("arst_done", int'(done), 0);
        rst = 1'b0;
        nextCycle();
        checkOutput("arst_idle", int'(busy), 0);

        // Random object placement and consumer rate
        for (int t = 0; t < 12; t++) begin
            ny = int'($urandom_range(270));
            for (int i = 0; i < NUM; i++) begin
                if ($urandom_range(7) == 0)
                    obj_y[i] = 8'((ny + 2 - int'($urandom_range(10))) & 255);
                else
                    obj_y[i] = 8'($urandom_range(255));
            end
            applyStimulus(ny, int'($urandom_range(20)), 30 + int'($urandom_range(70)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
